// File: rtl/player_keys_pkg.sv
// Shared scan-code constants and key-direction decode for the keyboard front end.
// Contents:
//   KEY_* / PS2_*  : PS/2 set-2 scan codes used by the player controls
//   dir_e          : direction index into the held-key register files
//   decode_dir()   : maps a scan code to a direction (hit=0 for non-direction codes)
package player_keys_pkg;

    localparam logic [7:0] KEY_UP    = 8'h75;
    localparam logic [7:0] KEY_DOWN  = 8'h72;
    localparam logic [7:0] KEY_LEFT  = 8'h6B;
    localparam logic [7:0] KEY_RIGHT = 8'h74;
    localparam logic [7:0] KEY_SPACE = 8'h29;
    localparam logic [7:0] PS2_EXT   = 8'hE0;
    localparam logic [7:0] PS2_BREAK = 8'hF0;

    localparam int NUM_DIRS = 4;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_e;

    typedef struct packed {
        logic hit;
        dir_e dir;
    } dir_decode_t;

    // The keypad and arrow keys share codes; the E0 prefix alone tells them apart.
    function automatic dir_decode_t decode_dir(input logic [7:0] code);
        dir_decode_t r;
        r.hit = 1'b1;
        r.dir = DIR_UP;
        case (code)
            KEY_UP:    r.dir = DIR_UP;
            KEY_DOWN:  r.dir = DIR_DOWN;
            KEY_LEFT:  r.dir = DIR_LEFT;
            KEY_RIGHT: r.dir = DIR_RIGHT;
            default:   r.hit = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/scan_code_parser.sv
// PS/2 make/break parser. Tracks the E0 (extended) and F0 (break) prefixes and
// emits one decoded key event per completed scan code, in the same cycle as the
// byte that completes it.
// Ports:
//   clk, resetN       : clock, asynchronous active-low reset
//   kbd_data[7:0]     : received byte, valid when kbd_valid
//   kbd_valid         : one-cycle byte strobe
//   key_event         : one-cycle strobe, a make or break was decoded
//   key_code[7:0]     : scan code of the event
//   key_ext           : event was E0-prefixed
//   key_make          : 1 = make (press), 0 = break (release)
module scan_code_parser
    import player_keys_pkg::*;
(
    input  logic       clk,
    input  logic       resetN,
    input  logic [7:0] kbd_data,
    input  logic       kbd_valid,
    output logic       key_event,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_make
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXT     = 2'd1,
        BRK     = 2'd2,
        EXT_BRK = 2'd3
    } state_e;

    state_e state, state_next;

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; combinational blocks use blocking (=).
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of this block is given a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        key_event  = 1'b0;
        key_code   = kbd_data;
        key_ext    = 1'b0;
        key_make   = 1'b0;
        if (kbd_valid) begin
            case (state)
                IDLE: begin
                    if (kbd_data == PS2_EXT) begin
                        state_next = EXT;
                    end else if (kbd_data == PS2_BREAK) begin
                        state_next = BRK;
                    end else begin
                        key_event = 1'b1;
                        key_make  = 1'b1;
                    end
                end
                EXT: begin
                    if (kbd_data == PS2_BREAK) begin
                        state_next = EXT_BRK;
                    end else if (kbd_data != PS2_EXT) begin
                        // A repeated E0 keeps waiting; anything else completes the code.
                        key_event  = 1'b1;
                        key_ext    = 1'b1;
                        key_make   = 1'b1;
                        state_next = IDLE;
                    end
                end
                BRK: begin
                    // Any byte after F0 is a break, even F0/E0 (they match no key).
                    key_event  = 1'b1;
                    state_next = IDLE;
                end
                EXT_BRK: begin
                    key_event  = 1'b1;
                    key_ext    = 1'b1;
                    state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

endmodule

// File: rtl/player_keys.sv
// Keyboard front end for the player: held-key tracking for the four directions
// (keypad and arrow keys tracked separately, then OR-ed), plus a frame-aligned,
// rate-limited fire pulse driven by Space.
// Parameters:
//   FIRE_COOLDOWN_FRAMES : minimum frames between fire pulses while Space is held
// Ports:
//   clk, resetN          : clock, asynchronous active-low reset
//   startOfFrame         : one-cycle pulse at each frame start
//   kbd_data[7:0]        : PS/2 byte, valid when kbd_valid
//   kbd_valid            : one-cycle byte strobe
//   move_left/right/up/down : registered direction levels
//   fire                 : one-cycle pulse, coincident with startOfFrame
module player_keys
    import player_keys_pkg::*;
#(
    parameter int FIRE_COOLDOWN_FRAMES = 8
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       startOfFrame,
    input  logic [7:0] kbd_data,
    input  logic       kbd_valid,
    output logic       move_left,
    output logic       move_right,
    output logic       move_up,
    output logic       move_down,
    output logic       fire
);

    localparam int CW = $clog2(FIRE_COOLDOWN_FRAMES + 1);
    localparam logic [CW-1:0] COOLDOWN_LOAD = CW'(FIRE_COOLDOWN_FRAMES - 1);

    logic       key_event;
    logic [7:0] key_code;
    logic       key_ext;
    logic       key_make;

    scan_code_parser u_parser (
        .clk       (clk),
        .resetN    (resetN),
        .kbd_data  (kbd_data),
        .kbd_valid (kbd_valid),
        .key_event (key_event),
        .key_code  (key_code),
        .key_ext   (key_ext),
        .key_make  (key_make)
    );

    logic [NUM_DIRS-1:0] keypad_held;
    logic [NUM_DIRS-1:0] arrow_held;
    logic                space_held;
    logic                fire_armed;
    logic [CW-1:0]       cooldown;

    dir_decode_t dec;
    logic        space_event;
    logic        space_make_edge;

    assign dec         = decode_dir(key_code);
    assign space_event = key_event && !key_ext && (key_code == KEY_SPACE);
    // Only a released-to-pressed transition arms; typematic repeats do not.
    assign space_make_edge = space_event && key_make && !space_held;

    // NOTE: the held-key bits are reset so a reset forgets every key; a key
    // still physically down is picked up again by its next typematic make.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            keypad_held <= '0;
            arrow_held  <= '0;
            space_held  <= 1'b0;
        end else begin
            if (key_event && dec.hit) begin
                if (key_ext) begin
                    arrow_held[dec.dir] <= key_make;
                end else begin
                    keypad_held[dec.dir] <= key_make;
                end
            end
            if (space_event) begin
                space_held <= key_make;
            end
        end
    end

    // Opposing directions are passed through; the movement block resolves them.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            move_up    <= 1'b0;
            move_down  <= 1'b0;
            move_left  <= 1'b0;
            move_right <= 1'b0;
        end else begin
            move_up    <= keypad_held[DIR_UP]    | arrow_held[DIR_UP];
            move_down  <= keypad_held[DIR_DOWN]  | arrow_held[DIR_DOWN];
            move_left  <= keypad_held[DIR_LEFT]  | arrow_held[DIR_LEFT];
            move_right <= keypad_held[DIR_RIGHT] | arrow_held[DIR_RIGHT];
        end
    end

    // Decided from pre-update state, so a Space make landing on a frame edge
    // cannot fire in that same cycle; it arms for the next frame instead.
    assign fire = startOfFrame && (cooldown == '0) && (space_held || fire_armed);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            cooldown   <= '0;
            fire_armed <= 1'b0;
        end else begin
            if (startOfFrame) begin
                if (cooldown != '0) begin
                    cooldown <= cooldown - CW'(1);
                end else if (fire) begin
                    cooldown <= COOLDOWN_LOAD;
                end
            end
            // A new make edge beats the clear from a fire in the same cycle.
            if (space_make_edge) begin
                fire_armed <= 1'b1;
            end else if (fire) begin
                fire_armed <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_player_keys.sv
module tb_player_keys;

    logic       clk;
    logic       resetN;
    logic       startOfFrame;
    logic [7:0] kbd_data;
    logic       kbd_valid;

    logic move_left, move_right, move_up, move_down, fire;
    logic m1_left, m1_right, m1_up, m1_down, fire1;

    int n_checks = 0;
    int n_fail   = 0;

    player_keys #(.FIRE_COOLDOWN_FRAMES(8)) dut (
        .clk          (clk),
        .resetN       (resetN),
        .startOfFrame (startOfFrame),
        .kbd_data     (kbd_data),
        .kbd_valid    (kbd_valid),
        .move_left    (move_left),
        .move_right   (move_right),
        .move_up      (move_up),
        .move_down    (move_down),
        .fire         (fire)
    );

    player_keys #(.FIRE_COOLDOWN_FRAMES(1)) dut1 (
        .clk          (clk),
        .resetN       (resetN),
        .startOfFrame (startOfFrame),
        .kbd_data     (kbd_data),
        .kbd_valid    (kbd_valid),
        .move_left    (m1_left),
        .move_right   (m1_right),
        .move_up      (m1_up),
        .move_down    (m1_down),
        .fire         (fire1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] moves();
        return {move_up, move_down, move_left, move_right};
    endfunction

    // One clock cycle starting at posedge+1: drive, sample fire mid-cycle,
    // return at the next posedge+1 with registered outputs settled.
    task automatic cycle(input logic sof, input logic v, input logic [7:0] d,
                         output logic f8, output logic f1);
        startOfFrame = sof;
        kbd_valid    = v;
        kbd_data     = d;
        @(negedge clk);
        f8 = fire;
        f1 = fire1;
        @(posedge clk);
        #1;
        startOfFrame = 1'b0;
        kbd_valid    = 1'b0;
    endtask

    task automatic send(input logic [7:0] d);
        logic f8, f1;
        cycle(1'b0, 1'b1, d, f8, f1);
    endtask

    task automatic run_idle(input int n);
        logic f8, f1;
        for (int i = 0; i < n; i++) begin
            cycle(1'b0, 1'b0, 8'h00, f8, f1);
            check("fire_off_frame", f8, 1'b0);
            check("fire1_off_frame", f1, 1'b0);
        end
    endtask

    task automatic frame(input logic exp8, input logic exp1, input string name);
        logic f8, f1;
        run_idle(3);
        cycle(1'b1, 1'b0, 8'h00, f8, f1);
        check({name, "_fire"}, f8, exp8);
        check({name, "_fire1"}, f1, exp1);
    endtask

    // ---------------- behavioural reference model ----------------
    bit m_held [0:511];   // index = ext*256 + code
    bit m_ext, m_brk;
    int m_frame;
    int m_next  [2];
    bit m_armed [2];
    int m_fcf   [2];

    task automatic model_reset();
        for (int i = 0; i < 512; i++) m_held[i] = 1'b0;
        m_ext = 1'b0;
        m_brk = 1'b0;
        m_frame = 0;
        for (int i = 0; i < 2; i++) begin
            m_next[i]  = 0;
            m_armed[i] = 1'b0;
        end
        m_fcf[0] = 8;
        m_fcf[1] = 1;
    endtask

    function automatic logic [3:0] model_moves();
        return {m_held[9'h075] | m_held[9'h175], m_held[9'h072] | m_held[9'h172],
                m_held[9'h06B] | m_held[9'h16B], m_held[9'h074] | m_held[9'h174]};
    endfunction

    task automatic model_step(input logic sof, input logic v, input logic [7:0] d,
                              output logic e8, output logic e1);
        logic e [2];
        int idx;
        for (int i = 0; i < 2; i++) begin
            e[i] = sof && (m_held[9'h029] || m_armed[i]) && (m_frame >= m_next[i]);
            if (e[i]) begin
                m_next[i]  = m_frame + m_fcf[i];
                m_armed[i] = 1'b0;
            end
        end
        if (sof) m_frame++;
        if (v) begin
            idx = (m_ext ? 256 : 0) + int'(d);
            if (m_brk) begin
                m_held[idx] = 1'b0;
                m_ext = 1'b0;
                m_brk = 1'b0;
            end else if (d == 8'hE0) begin
                m_ext = 1'b1;
            end else if (d == 8'hF0) begin
                m_brk = 1'b1;
            end else begin
                if (idx == 'h029 && !m_held[idx]) begin
                    m_armed[0] = 1'b1;
                    m_armed[1] = 1'b1;
                end
                m_held[idx] = 1'b1;
                m_ext = 1'b0;
            end
        end
        e8 = e[0];
        e1 = e[1];
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic       sof;
        logic       v;
        logic [7:0] d;
        logic [3:0] exp_move;   // {up,down,left,right} after this cycle's edge
        logic       exp_fire;
    } vec_t;

    vec_t vecs[$];

    initial begin
        logic f8, f1;
        logic e8, e1;
        logic [3:0] em;
        logic sof, v, prev_v;
        logic [7:0] d;

        // keypad 8 make, arrow right make, keypad 8 break
        vecs.push_back('{1'b0, 1'b1, 8'h75, 4'b0000, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 8'h00, 4'b1000, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 8'hE0, 4'b1000, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 8'h74, 4'b1000, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 8'h00, 4'b1001, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 8'hF0, 4'b1001, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 8'h75, 4'b1001, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 8'h00, 4'b0001, 1'b0});
        // keypad 6 also held; release arrow first, then keypad
        vecs.push_back('{1'b0, 1'b1, 8'h74, 4'b0001, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 8'h00, 4'b0001, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 8'hE0, 4'b0001, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 8'hF0, 4'b0001, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 8'h74, 4'b0001, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 8'h00, 4'b0001, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 8'hF0, 4'b0001, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 8'h74, 4'b0001, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 8'h00, 4'b0000, 1'b0});
        // E0 E0 72 is still the arrow down; E1/AA only pass through the FSM
        vecs.push_back('{1'b0, 1'b1, 8'hE0, 4'b0000, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 8'hE0, 4'b0000, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 8'h72, 4'b0000, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 8'hAA, 4'b0100, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 8'hF0, 4'b0100, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 8'h72, 4'b0100, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 8'h00, 4'b0100, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 8'hE0, 4'b0100, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 8'hF0, 4'b0100, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 8'h72, 4'b0100, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 8'h00, 4'b0000, 1'b0});

        resetN       = 1'b0;
        startOfFrame = 1'b0;
        kbd_valid    = 1'b0;
        kbd_data     = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check("reset_moves", moves(), 4'b0000);
        check("reset_fire", fire, 1'b0);
        resetN = 1'b1;
        run_idle(2);
        check("idle_moves", moves(), 4'b0000);

        // ---- table ----
        for (int i = 0; i < vecs.size(); i++) begin
            cycle(vecs[i].sof, vecs[i].v, vecs[i].d, f8, f1);
            check($sformatf("vec%0d_move", i), moves(), vecs[i].exp_move);
            check($sformatf("vec%0d_fire", i), f8, vecs[i].exp_fire);
        end

        // ---- typematic left ----
        for (int i = 0; i < 10; i++) begin
            send(8'h6B);
            run_idle(1);
            check("typematic_left_held", move_left, 1'b1);
        end
        send(8'hF0);
        check("typematic_left_f0", move_left, 1'b1);
        send(8'h6B);
        check("typematic_left_brk", move_left, 1'b1);
        run_idle(1);
        check("typematic_left_released", move_left, 1'b0);

        // E0 29 is not Space
        send(8'hE0);
        send(8'h29);
        frame(1'b0, 1'b0, "ext_space");
        send(8'hE0);
        send(8'hF0);
        send(8'h29);

        // ---- Space held 20 frames ----
        send(8'h29);
        for (int fr = 1; fr <= 20; fr++) begin
            frame((fr == 1) || (fr == 9) || (fr == 17), 1'b1, $sformatf("hold_fr%0d", fr));
        end
        send(8'hF0);
        send(8'h29);
        for (int fr = 21; fr <= 25; fr++) begin
            frame(1'b0, 1'b0, $sformatf("released_fr%0d", fr));
        end

        // ---- taps: one immediately, a second inside the cooldown ----
        send(8'h29);
        send(8'hF0);
        send(8'h29);
        for (int fr = 1; fr <= 10; fr++) begin
            frame((fr == 1) || (fr == 9), (fr == 1) || (fr == 4), $sformatf("tap_fr%0d", fr));
            if (fr == 3) begin
                send(8'h29);
                send(8'hF0);
                send(8'h29);
            end
        end
        for (int fr = 11; fr <= 17; fr++) begin
            frame(1'b0, 1'b0, $sformatf("cool_fr%0d", fr));
        end

        // ---- Space make coincident with startOfFrame ----
        cycle(1'b1, 1'b1, 8'h29, f8, f1);
        check("coincident_fire", f8, 1'b0);
        check("coincident_fire1", f1, 1'b0);
        send(8'hF0);
        send(8'h29);
        frame(1'b1, 1'b1, "coincident_next");
        frame(1'b0, 1'b0, "coincident_after");

        // ---- reset after an E0 prefix ----
        send(8'h75);
        run_idle(1);
        check("pre_reset_up", move_up, 1'b1);
        send(8'hE0);
        #2;
        resetN = 1'b0;
        #1;
        check("in_reset_moves", moves(), 4'b0000);
        startOfFrame = 1'b1;
        #1;
        check("in_reset_fire", fire, 1'b0);
        check("in_reset_fire1", fire1, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        startOfFrame = 1'b0;
        check("in_reset_moves_late", moves(), 4'b0000);
        resetN = 1'b1;
        send(8'h72);
        run_idle(1);
        check("post_reset_moves", moves(), 4'b0100);
        send(8'hF0);
        send(8'h72);
        run_idle(1);
        check("post_reset_release", moves(), 4'b0000);

        // ---- randomized run against the reference model ----
        #2;
        resetN = 1'b0;
        @(posedge clk);
        #1;
        resetN = 1'b1;
        model_reset();
        prev_v = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            v   = !prev_v && ($urandom_range(0, 2) == 0);
            sof = ($urandom_range(0, 6) == 0);
            case ($urandom_range(0, 13))
                0:       d = 8'h75;
                1:       d = 8'h72;
                2:       d = 8'h6B;
                3:       d = 8'h74;
                4, 5:    d = 8'h29;
                6, 7:    d = 8'hF0;
                8, 9:    d = 8'hE0;
                10:      d = 8'hE1;
                11:      d = 8'hAA;
                12:      d = ($urandom_range(0, 1) == 0) ? 8'hFA : 8'hFE;
                default: d = 8'($urandom_range(0, 255));
            endcase
            em = model_moves();
            model_step(sof, v, d, e8, e1);
            cycle(sof, v, d, f8, f1);
            check($sformatf("rnd%0d_move", i), moves(), em);
            check($sformatf("rnd%0d_fire", i), f8, e8);
            check($sformatf("rnd%0d_fire1", i), f1, e1);
            prev_v = v;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/player_keys.md
# player_keys

Keyboard front end for the player. It consumes the byte stream from the PS/2 receiver and tracks make/break codes, including the E0 extended prefix, to hold a per-key pressed state. It drives the `move_left/right/up/down` levels into `player_move`, and a frame-aligned, rate-limited `fire` pulse for the player missile logic. It sits directly upstream of `player_move`, in the `clk` domain.

## Interface
- `FIRE_COOLDOWN_FRAMES`, default 8: minimum number of frames between two `fire` pulses while Space is held.
- `clk  in  1`: system clock.
- `resetN  in  1`: asynchronous, active-low reset.
- `startOfFrame  in  1`: one-cycle pulse at each frame start (30 Hz).
- `kbd_data  in  8`: received PS/2 byte.
- `kbd_valid  in  1`: one-cycle strobe; `kbd_data` is valid in that cycle.
- `move_left  out  1`: left key held (keypad 4 or left arrow).
- `move_right  out  1`: right key held (keypad 6 or right arrow).
- `move_up  out  1`: up key held (keypad 8 or up arrow).
- `move_down  out  1`: down key held (keypad 2 or down arrow).
- `fire  out  1`: one-cycle pulse, coincident with `startOfFrame`.

## Operation
- **Parser FSM states:**
  - IDLE.
  - EXT: after E0.
  - BRK: after F0.
  - EXT_BRK: after E0 then F0.
- **Transitions.** All transitions happen only on `kbd_valid`.
  - IDLE: E0 → EXT; F0 → BRK; any other byte → decode as make (ext=0), stay in IDLE.
  - EXT: F0 → EXT_BRK; E0 → stay in EXT; other byte → decode as make (ext=1), go to IDLE.
  - BRK: decode as break (ext=0), go to IDLE. The F0 → F0 case is decoded as break of 0xF0, which matches no key.
  - EXT_BRK: decode as break (ext=1), go to IDLE.
- **Key decode:**
  - Codes 75/72/6B/74 map to up/down/left/right.
  - The same codes are tracked separately for ext=0 (keypad) and ext=1 (arrows). This gives 8 held bits.
  - Code 29 with ext=0 is Space. Space with ext=1 is ignored.
  - Unknown codes are ignored. Received E1, AA, FA and FE bytes only move the FSM along the rules above.
- **Held state:**
  - A make sets the key's bit; a break clears it.
  - Typematic repeat makes are idempotent.
- **Direction outputs:**
  - `move_X` = keypad_X OR arrow_X, registered.
  - Opposing directions are not cancelled here; `player_move` resolves them.
- **Fire:**
  - `space_held` bit, plus a 1-bit `fire_armed` flag set on every Space make edge (0 → 1 transition only).
  - `cooldown` frame counter, width $clog2(FIRE_COOLDOWN_FRAMES+1).
  - On `startOfFrame`: if `cooldown` ≠ 0, decrement it. Otherwise, if `space_held` or `fire_armed`, assert `fire`, load `cooldown` = FIRE_COOLDOWN_FRAMES−1 and clear `fire_armed`.
  - Net effect: a tap shorter than one frame still fires exactly once, and a held key fires every FIRE_COOLDOWN_FRAMES frames.
- **FIRE_COOLDOWN_FRAMES = 1** means a fire pulse on every frame while Space is held.

## Timing
- Reset state: FSM in IDLE; all held bits 0; `fire_armed` 0; `cooldown` 0; every output 0.
- Latency: a `kbd_valid` byte in cycle N updates held bits at edge N+1. `move_*` are registered and reflect the byte at N+2.
- `fire` is asserted in the same cycle as `startOfFrame`: combinational from registered state and `startOfFrame`. It is never wider than one cycle.
- Simultaneous `kbd_valid` and `startOfFrame`:
  - The frame logic uses the pre-update `space_held` and `fire_armed`.
  - If a Space make lands in that same cycle, `fire_armed` is set and fires on the next frame.
  - The clear of `fire_armed` and a new set in the same cycle: set wins.
- `kbd_valid` is never asserted on consecutive cycles with the same byte twice; every strobe is one byte.
- Reset asserted mid-sequence (e.g. after E0): the FSM returns to IDLE. Held keys are forgotten; the next make re-asserts them.

## Structure
- Scan-code constants go into `parameters.sv`, the shared parameter file: `KEY_UP`, `KEY_DOWN`, `KEY_LEFT`, `KEY_RIGHT`, `KEY_SPACE`, `PS2_EXT`, `PS2_BREAK`.
- The FSM state enum stays local to this block.
- Sub-module `scan_code_parser`:
  - Contains the 4-state FSM.
  - Outputs one-cycle `key_event`, `key_code[7:0]`, `key_ext`, `key_make`.
- `player_keys` holds the held-state register file and the fire/cooldown logic.

## Test plan
- Reset, then feed bytes 75, then E0 74 → `move_up`=1 two cycles after the 75 strobe; `move_right`=1 after 74. Then F0 75 → `move_up`=0; `move_right` stays 1.
- Keypad 6 (74) held and right arrow (E0 74) held; release E0 F0 74 → `move_right` stays 1. Then release F0 74 → `move_right`=0.
- Typematic: 6B sent ten times, then F0 6B → `move_left` is 1 throughout and drops only on the break.
- Space held for 20 frames with FIRE_COOLDOWN_FRAMES=8 → `fire` on frames 1, 9, 17 only; each pulse is one cycle and aligned to `startOfFrame`.
- Space tap between two frames (29, F0 29): exactly one `fire` at the next `startOfFrame`. A second tap within the cooldown fires when `cooldown` reaches 0.
- After E0, assert `resetN` low, then release and send 72 → `move_down`=1 (ext=0 path): no stale prefix survives, and all outputs were 0 during reset.
